// File: rtl/debug_uart_tx_if.sv
// Snapshot request, captured debug ports and UART status for debug_uart_tx.
// master drives the request side; slave is the transmitter.
interface debug_uart_tx_if;
    logic       trigger;
    logic [7:0] debug_port1;
    logic [7:0] debug_port2;
    logic [7:0] debug_port3;
    logic [7:0] debug_port4;
    logic [7:0] debug_port5;
    logic [7:0] debug_port6;
    logic [7:0] debug_port7;
    logic       tx;
    logic       busy;
    logic       frame_done;

    modport master (
        output trigger,
        output debug_port1, debug_port2, debug_port3, debug_port4,
        output debug_port5, debug_port6, debug_port7,
        input  tx, busy, frame_done
    );

    modport slave (
        input  trigger,
        input  debug_port1, debug_port2, debug_port3, debug_port4,
        input  debug_port5, debug_port6, debug_port7,
        output tx, busy, frame_done
    );
endinterface

// File: rtl/debug_uart_tx.sv
// Snapshots the seven CPU debug ports and sends them as an 8N1 frame (A5, ports, [checksum]).
// Define DEBUG_UART_TX_CHECKSUM_EN to append the modulo-256 checksum byte.
module debug_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic            clk,
    input  logic            reset,
    debug_uart_tx_if.slave  dbg
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int unsigned       BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
`ifdef DEBUG_UART_TX_CHECKSUM_EN
    localparam logic [3:0]        LAST_BYTE = 4'd8;
`else
    localparam logic [3:0]        LAST_BYTE = 4'd7;
`endif

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [3:0]          byte_q, byte_d;
    logic [55:0]         snap_q, snap_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [7:0]          cur_byte;
    logic [2:0]          bit_nxt;

`ifdef DEBUG_UART_TX_CHECKSUM_EN
    logic [7:0] checksum;

    always_comb begin
        checksum = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            checksum = checksum + snap_q[8*i +: 8];
        end
    end
`endif

    always_comb begin
        cur_byte = 8'hA5;
        case (byte_q)
            4'd1:    cur_byte = snap_q[7:0];
            4'd2:    cur_byte = snap_q[15:8];
            4'd3:    cur_byte = snap_q[23:16];
            4'd4:    cur_byte = snap_q[31:24];
            4'd5:    cur_byte = snap_q[39:32];
            4'd6:    cur_byte = snap_q[47:40];
            4'd7:    cur_byte = snap_q[55:48];
`ifdef DEBUG_UART_TX_CHECKSUM_EN
            4'd8:    cur_byte = checksum;
`endif
            default: cur_byte = 8'hA5;
        endcase
    end

    assign bit_nxt = bit_q + 3'd1;

    // tx_d carries the level of the bit being entered, so tx stays a pure flop output.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        snap_d  = snap_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (dbg.trigger) begin
                    state_d = START;
                    snap_d  = {dbg.debug_port7, dbg.debug_port6, dbg.debug_port5,
                               dbg.debug_port4, dbg.debug_port3, dbg.debug_port2,
                               dbg.debug_port1};
                    byte_d  = '0;
                    bit_d   = '0;
                    baud_d  = BAUD_LOAD;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (baud_q == '0) begin
                    state_d = DATA;
                    baud_d  = BAUD_LOAD;
                    bit_d   = '0;
                    tx_d    = cur_byte[0];
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            DATA: begin
                if (baud_q == '0) begin
                    baud_d = BAUD_LOAD;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_nxt;
                        tx_d  = cur_byte[bit_nxt];
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            STOP: begin
                if (baud_q == '0) begin
                    bit_d = '0;
                    if (byte_q == LAST_BYTE) begin
                        state_d = IDLE;
                        baud_d  = '0;
                        byte_d  = '0;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = START;
                        baud_d  = BAUD_LOAD;
                        byte_d  = byte_q + 4'd1;
                        tx_d    = 1'b0;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            snap_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            snap_q  <= snap_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign dbg.tx         = tx_q;
    assign dbg.busy       = busy_q;
    assign dbg.frame_done = done_q;

endmodule
